// File: rtl/reg_bank_32x32_if.sv
// Bus bundle for the 32x32 register bank: write port, two read ports,
// the clear-sweep handshake and the flattened word outputs to the selector.
interface reg_bank_32x32_if #(
  parameter int WIDTH = 32
);
  logic                   we;
  logic [4:0]             waddr;
  logic [WIDTH-1:0]       wdata;
  logic [4:0]             raddr1;
  logic [4:0]             raddr2;
  logic [WIDTH-1:0]       rdata1;
  logic [WIDTH-1:0]       rdata2;
  logic                   clr_req;
  logic                   busy;
  logic [32*WIDTH-1:0]    regs_flat;

  // Driver side (requester of writes, reads and clears).
  modport master (
    output we, waddr, wdata, raddr1, raddr2, clr_req,
    input  rdata1, rdata2, busy, regs_flat
  );

  // Register bank side.
  modport slave (
    input  we, waddr, wdata, raddr1, raddr2, clr_req,
    output rdata1, rdata2, busy, regs_flat
  );
endinterface

// File: rtl/reg_bank_32x32.sv
// 32 x WIDTH register bank feeding the 32-input word selector.
// One synchronous write port, two combinational read ports with optional
// write-through bypass, and a sequencer that zeroes registers 1..31 one per
// cycle after a clear request. Register 0 always reads as zero.
module reg_bank_32x32 #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b1
) (
  input logic             clk,
  input logic             rst,
  reg_bank_32x32_if.slave bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } bankState_t;

  bankState_t       stateReg;
  bankState_t       stateNext;
  logic [4:0]       sweepCntReg;
  logic [4:0]       sweepCntNext;
  logic             busyReg;
  logic             busyNext;
  logic             clrActive;
  logic             wrAccept;
  logic [WIDTH-1:0] regFile [0:31];
  logic [WIDTH-1:0] stored1;
  logic [WIDTH-1:0] stored2;
  logic             bypass1;
  logic             bypass2;

  // Writes are only taken while no sweep runs; address 0 is never written.
  assign wrAccept = bus.we && !busyReg && (bus.waddr != 5'd0);

  // Clear sequencer: next state, sweep pointer and busy flag.
  always_comb begin
    stateNext    = stateReg;
    sweepCntNext = sweepCntReg;
    clrActive    = 1'b0;
    case (stateReg)
      IDLE: begin
        sweepCntNext = 5'd1;
        if (bus.clr_req) begin
          stateNext = SWEEP;
        end
      end
      SWEEP: begin
        // clr_req is deliberately not looked at here: no re-trigger, no queue.
        clrActive = 1'b1;
        if (sweepCntReg == 5'd31) begin
          stateNext    = IDLE;
          sweepCntNext = 5'd1;
        end else begin
          sweepCntNext = sweepCntReg + 5'd1;
        end
      end
      default: begin
        stateNext    = IDLE;
        sweepCntNext = 5'd1;
      end
    endcase
    // busy is a flop so it rises in the first SWEEP cycle and falls the
    // cycle after register 31 has been cleared.
    busyNext = (stateNext == SWEEP);
  end

  // Sequencer state register with synchronous reset (aborts any sweep).
  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg    <= IDLE;
      sweepCntReg <= 5'd1;
      busyReg     <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      sweepCntReg <= sweepCntNext;
      busyReg     <= busyNext;
    end
  end

  // Register storage: sweep clear takes precedence, writes are gated off
  // while busy anyway so both never target the same word in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regFile[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (clrActive && (sweepCntReg == 5'(i))) begin
          regFile[i] <= '0;
        end else if (wrAccept && (bus.waddr == 5'(i))) begin
          regFile[i] <= bus.wdata;
        end
      end
    end
  end

  // Combinational read ports; address 0 is forced to zero, and the bypass
  // forwards the write data only when that write will actually be accepted.
  always_comb begin
    stored1 = (bus.raddr1 == 5'd0) ? '0 : regFile[bus.raddr1];
    stored2 = (bus.raddr2 == 5'd0) ? '0 : regFile[bus.raddr2];
    bypass1 = BYPASS && wrAccept && (bus.waddr == bus.raddr1);
    bypass2 = BYPASS && wrAccept && (bus.waddr == bus.raddr2);
    bus.rdata1 = bypass1 ? bus.wdata : stored1;
    bus.rdata2 = bypass2 ? bus.wdata : stored2;
  end

  assign bus.busy = busyReg;

  // Selector feed: stored values only, word k on input k, word 0 tied low.
  for (genvar gi = 0; gi < 32; gi++) begin : gFlat
    if (gi == 0) begin : gZero
      assign bus.regs_flat[WIDTH-1:0] = '0;
    end else begin : gWord
      assign bus.regs_flat[gi*WIDTH +: WIDTH] = regFile[gi];
    end
  end

endmodule

// File: tb/tb_reg_bank_32x32.sv
// Directed bench for reg_bank_32x32: one bypassing and one non-bypassing
// instance receive identical stimulus; each scenario task checks inline.
module tb_reg_bank_32x32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_bank_32x32_if #(.WIDTH(32)) busA ();
  reg_bank_32x32_if #(.WIDTH(32)) busB ();

  reg_bank_32x32 #(.WIDTH(32), .BYPASS(1'b1)) dutA (.clk(clk), .rst(rst), .bus(busA));
  reg_bank_32x32 #(.WIDTH(32), .BYPASS(1'b0)) dutB (.clk(clk), .rst(rst), .bus(busB));

  function automatic logic [31:0] wordOf(input logic [1023:0] flat, input int k);
    return flat[k*32 +: 32];
  endfunction

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic clr);
    busA.we = we; busA.waddr = wa; busA.wdata = wd;
    busA.raddr1 = r1; busA.raddr2 = r2; busA.clr_req = clr;
    busB.we = we; busB.waddr = wa; busB.wdata = wd;
    busB.raddr1 = r1; busB.raddr2 = r2; busB.clr_req = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    tick();
    tick();
    settle();
    checks++; if (busA.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_a got=%b exp=0", busA.busy); end
    checks++; if (busB.busy !== 1'b0) begin errors++; $display("FAIL reset_busy_b got=%b exp=0", busB.busy); end
    checks++; if (busA.regs_flat !== '0) begin errors++; $display("FAIL reset_flat_a got=%h exp=0", busA.regs_flat); end
    checks++; if (busB.regs_flat !== '0) begin errors++; $display("FAIL reset_flat_b got=%h exp=0", busB.regs_flat); end
    rst = 1'b0;
  endtask

  task automatic test_write();
    logic [1023:0] expFlat;
    expFlat = '0;
    expFlat[191:160] = 32'hDEADBEEF;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b0);
    settle();
    checks++; if (busA.rdata1 !== 32'hDEADBEEF) begin errors++; $display("FAIL write_bypass_a got=%h exp=deadbeef", busA.rdata1); end
    checks++; if (busB.rdata1 !== 32'h0) begin errors++; $display("FAIL write_nobypass_b got=%h exp=0", busB.rdata1); end
    checks++; if (wordOf(busA.regs_flat, 5) !== 32'h0) begin errors++; $display("FAIL write_flat_early got=%h exp=0", wordOf(busA.regs_flat, 5)); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0);
    settle();
    checks++; if (busA.regs_flat !== expFlat) begin errors++; $display("FAIL write_flat_a got=%h exp=%h", busA.regs_flat, expFlat); end
    checks++; if (busA.rdata1 !== 32'hDEADBEEF) begin errors++; $display("FAIL write_read_a got=%h exp=deadbeef", busA.rdata1); end
    checks++; if (busB.rdata1 !== 32'hDEADBEEF) begin errors++; $display("FAIL write_read_b got=%h exp=deadbeef", busB.rdata1); end
  endtask

  task automatic test_r0();
    logic [1023:0] expFlat;
    expFlat = '0;
    expFlat[191:160] = 32'hDEADBEEF;
    drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0);
    settle();
    checks++; if (busA.rdata1 !== 32'h0) begin errors++; $display("FAIL r0_rdata1_same got=%h exp=0", busA.rdata1); end
    checks++; if (busA.rdata2 !== 32'h0) begin errors++; $display("FAIL r0_rdata2_same got=%h exp=0", busA.rdata2); end
    checks++; if (wordOf(busA.regs_flat, 0) !== 32'h0) begin errors++; $display("FAIL r0_flat_same got=%h exp=0", wordOf(busA.regs_flat, 0)); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    settle();
    checks++; if (busA.rdata1 !== 32'h0) begin errors++; $display("FAIL r0_rdata1_next got=%h exp=0", busA.rdata1); end
    checks++; if (busB.regs_flat !== expFlat) begin errors++; $display("FAIL r0_flat_next got=%h exp=%h", busB.regs_flat, expFlat); end
  endtask

  task automatic test_bypass();
    drive(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 1'b0);
    settle();
    checks++; if (busA.rdata1 !== 32'h12345678) begin errors++; $display("FAIL byp_rdata1_a got=%h exp=12345678", busA.rdata1); end
    checks++; if (busA.rdata2 !== 32'h12345678) begin errors++; $display("FAIL byp_rdata2_a got=%h exp=12345678", busA.rdata2); end
    checks++; if (wordOf(busA.regs_flat, 7) !== 32'h0) begin errors++; $display("FAIL byp_flat7_a got=%h exp=0", wordOf(busA.regs_flat, 7)); end
    checks++; if (busB.rdata1 !== 32'h0) begin errors++; $display("FAIL byp_rdata1_b got=%h exp=0", busB.rdata1); end
    checks++; if (busB.rdata2 !== 32'h0) begin errors++; $display("FAIL byp_rdata2_b got=%h exp=0", busB.rdata2); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0);
    settle();
    checks++; if (busB.rdata1 !== 32'h12345678) begin errors++; $display("FAIL byp_stored_b got=%h exp=12345678", busB.rdata1); end
    checks++; if (wordOf(busA.regs_flat, 7) !== 32'h12345678) begin errors++; $display("FAIL byp_flat7_next got=%h exp=12345678", wordOf(busA.regs_flat, 7)); end
  endtask

  task automatic test_fill();
    for (int k = 1; k < 32; k++) begin
      drive(1'b1, 5'(k), 32'(k), 5'd0, 5'd0, 1'b0);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    settle();
    for (int k = 0; k < 32; k++) begin
      checks++; if (wordOf(busA.regs_flat, k) !== 32'(k)) begin errors++; $display("FAIL fill_word%0d got=%h exp=%h", k, wordOf(busA.regs_flat, k), 32'(k)); end
    end
  endtask

  task automatic test_sweep();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1);
    settle();
    checks++; if (busA.busy !== 1'b0) begin errors++; $display("FAIL sweep_busy_pre got=%b exp=0", busA.busy); end
    tick();
    for (int s = 1; s < 32; s++) begin
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
      if (s == 5)  drive(1'b1, 5'd3, 32'h33333333, 5'd3, 5'd0, 1'b0);
      if (s == 10) drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1);
      settle();
      checks++; if (busA.busy !== 1'b1) begin errors++; $display("FAIL sweep_busy_a step%0d got=%b exp=1", s, busA.busy); end
      checks++; if (busB.busy !== 1'b1) begin errors++; $display("FAIL sweep_busy_b step%0d got=%b exp=1", s, busB.busy); end
      checks++; if (wordOf(busA.regs_flat, s) !== 32'(s)) begin errors++; $display("FAIL sweep_pending step%0d got=%h exp=%h", s, wordOf(busA.regs_flat, s), 32'(s)); end
      if (s > 1) begin
        checks++; if (wordOf(busA.regs_flat, s - 1) !== 32'h0) begin errors++; $display("FAIL sweep_cleared step%0d got=%h exp=0", s, wordOf(busA.regs_flat, s - 1)); end
      end
      if (s == 5) begin
        checks++; if (busA.rdata1 !== 32'h0) begin errors++; $display("FAIL sweep_no_bypass got=%h exp=0", busA.rdata1); end
      end
      if (s == 6) begin
        checks++; if (wordOf(busA.regs_flat, 3) !== 32'h0) begin errors++; $display("FAIL sweep_write_dropped got=%h exp=0", wordOf(busA.regs_flat, 3)); end
      end
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    settle();
    checks++; if (busA.busy !== 1'b0) begin errors++; $display("FAIL sweep_busy_end_a got=%b exp=0", busA.busy); end
    checks++; if (busB.busy !== 1'b0) begin errors++; $display("FAIL sweep_busy_end_b got=%b exp=0", busB.busy); end
    checks++; if (busA.regs_flat !== '0) begin errors++; $display("FAIL sweep_flat_end got=%h exp=0", busA.regs_flat); end
    tick();
    settle();
    checks++; if (busA.busy !== 1'b0) begin errors++; $display("FAIL sweep_no_extend got=%b exp=0", busA.busy); end
  endtask

  task automatic test_simul();
    drive(1'b1, 5'd31, 32'hA5A5A5A5, 5'd0, 5'd0, 1'b1);
    settle();
    checks++; if (busA.busy !== 1'b0) begin errors++; $display("FAIL simul_busy_pre got=%b exp=0", busA.busy); end
    tick();
    for (int s = 1; s < 32; s++) begin
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
      settle();
      checks++; if (wordOf(busA.regs_flat, 31) !== 32'hA5A5A5A5) begin errors++; $display("FAIL simul_reg31 step%0d got=%h exp=a5a5a5a5", s, wordOf(busA.regs_flat, 31)); end
      checks++; if (busA.busy !== 1'b1) begin errors++; $display("FAIL simul_busy step%0d got=%b exp=1", s, busA.busy); end
      tick();
    end
    settle();
    checks++; if (wordOf(busA.regs_flat, 31) !== 32'h0) begin errors++; $display("FAIL simul_reg31_end got=%h exp=0", wordOf(busA.regs_flat, 31)); end
    checks++; if (busA.busy !== 1'b0) begin errors++; $display("FAIL simul_busy_end got=%b exp=0", busA.busy); end
  endtask

  task automatic test_rst_mid();
    drive(1'b1, 5'd20, 32'h11111111, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd2, 32'h22222222, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1);
    tick();
    for (int s = 1; s < 10; s++) begin
      drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
      tick();
    end
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    rst = 1'b1;
    settle();
    checks++; if (busA.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre got=%b exp=1", busA.busy); end
    checks++; if (wordOf(busA.regs_flat, 20) !== 32'h11111111) begin errors++; $display("FAIL rstmid_reg20_pre got=%h exp=11111111", wordOf(busA.regs_flat, 20)); end
    checks++; if (wordOf(busA.regs_flat, 2) !== 32'h0) begin errors++; $display("FAIL rstmid_reg2_pre got=%h exp=0", wordOf(busA.regs_flat, 2)); end
    tick();
    rst = 1'b0;
    drive(1'b1, 5'd12, 32'hCAFEF00D, 5'd12, 5'd0, 1'b0);
    settle();
    checks++; if (busA.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_a got=%b exp=0", busA.busy); end
    checks++; if (busB.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_b got=%b exp=0", busB.busy); end
    checks++; if (busA.regs_flat !== '0) begin errors++; $display("FAIL rstmid_flat got=%h exp=0", busA.regs_flat); end
    checks++; if (busA.rdata1 !== 32'hCAFEF00D) begin errors++; $display("FAIL rstmid_bypass_a got=%h exp=cafef00d", busA.rdata1); end
    checks++; if (busB.rdata1 !== 32'h0) begin errors++; $display("FAIL rstmid_nobypass_b got=%h exp=0", busB.rdata1); end
    tick();
    drive(1'b0, 5'd0, 32'h0, 5'd12, 5'd0, 1'b0);
    settle();
    checks++; if (wordOf(busA.regs_flat, 12) !== 32'hCAFEF00D) begin errors++; $display("FAIL rstmid_write_a got=%h exp=cafef00d", wordOf(busA.regs_flat, 12)); end
    checks++; if (busB.rdata1 !== 32'hCAFEF00D) begin errors++; $display("FAIL rstmid_write_b got=%h exp=cafef00d", busB.rdata1); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_r0();
    test_bypass();
    test_fill();
    test_sweep();
    test_simul();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
